// File: rtl/write_buffer_drain_pkg.sv
// Shared types and entry layout helpers for the write-buffer drain block.
// Entry layout, MSB first: {word address, data, strobe}.
package write_buffer_drain_pkg;

    localparam int DEF_ADDR_W = 30;
    localparam int DEF_DATA_W = 32;
    localparam int STRB_LSB   = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } wbuf_state_t;

    function automatic int data_lsb(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int addr_lsb(input int data_w);
        return data_w + data_w / 8;
    endfunction

    function automatic int entry_w(input int addr_w, input int data_w);
        return addr_w + data_w + data_w / 8;
    endfunction

endpackage

// File: rtl/write_buffer_drain_skid.sv
// One-entry skid register holding a prefetched write entry.
// pend marks the cycle the FIFO read data arrives; valid marks a held entry.
module wbuf_drain_skid
    import write_buffer_drain_pkg::*;
#(
    parameter int ENTRY_W = 66,
    parameter int STRB_W  = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               launch,
    input  logic               abandon,
    input  logic               consume,
    input  logic [ENTRY_W-1:0] din,
    output logic               pend,
    output logic               valid,
    output logic [ENTRY_W-1:0] dout
);

    logic live;

    // Zero-strobe entries are dropped; a handshake during pend hands
    // the arriving entry to FETCH instead.
    assign live = pend & ~abandon & (din[STRB_LSB +: STRB_W] != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            pend  <= 1'b0;
            valid <= 1'b0;
            dout  <= '0;
        end else begin
            pend <= launch;
            if (live) begin
                valid <= 1'b1;
                dout  <= din;
            end else if (consume) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/write_buffer_drain.sv
// Drains write-through buffer entries onto the memory write bus.
// Define WBUF_DRAIN_PREFETCH_EN to prefetch the next entry during SEND.
module write_buffer_drain
    import write_buffer_drain_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    localparam int STRB_W  = DATA_W / 8,
    localparam int ENTRY_W = entry_w(ADDR_W, DATA_W),
    localparam int BYTE_W  = $clog2(STRB_W)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     buf_empty,
    input  logic [ENTRY_W-1:0]       buf_dataout,
    output logic                     buf_rd,
    output logic                     mem_valid,
    output logic [ADDR_W+BYTE_W-1:0] mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic [STRB_W-1:0]        mem_wstrb,
    input  logic                     mem_ready,
    output logic                     drain_idle
);

    localparam int DATA_LSB = data_lsb(DATA_W);
    localparam int ADDR_LSB = addr_lsb(DATA_W);

    wbuf_state_t state, state_nxt;

    logic               hs;
    logic               pf_pend;
    logic               pf_valid;
    logic               pf_launch;
    logic [ENTRY_W-1:0] pf_entry;
    logic [STRB_W-1:0]  in_strb;

    assign hs      = mem_valid & mem_ready;
    assign in_strb = buf_dataout[STRB_LSB +: STRB_W];

`ifdef WBUF_DRAIN_PREFETCH_EN
    assign pf_launch = (state == SEND) & ~buf_empty & ~pf_pend & ~pf_valid;

    // A launch that coincides with a handshake goes straight to FETCH.
    wbuf_drain_skid #(
        .ENTRY_W (ENTRY_W),
        .STRB_W  (STRB_W)
    ) u_skid (
        .clock   (clock),
        .reset   (reset),
        .launch  (pf_launch & ~hs),
        .abandon (hs),
        .consume (hs & pf_valid),
        .din     (buf_dataout),
        .pend    (pf_pend),
        .valid   (pf_valid),
        .dout    (pf_entry)
    );
`else
    assign pf_launch = 1'b0;
    assign pf_pend   = 1'b0;
    assign pf_valid  = 1'b0;
    assign pf_entry  = '0;
`endif

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (!buf_empty) state_nxt = FETCH;
            FETCH: state_nxt = (in_strb != '0) ? SEND : IDLE;
            SEND: begin
                if (hs) begin
                    if (pf_valid)                 state_nxt = SEND;
                    else if (pf_pend | pf_launch) state_nxt = FETCH;
                    else                          state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        buf_rd     = ((state == IDLE) & ~buf_empty) | pf_launch;
        drain_idle = buf_empty & (state == IDLE) & ~pf_pend & ~pf_valid;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            unique case (state)
                FETCH: begin
                    mem_addr  <= {buf_dataout[ADDR_LSB +: ADDR_W], {BYTE_W{1'b0}}};
                    mem_wdata <= buf_dataout[DATA_LSB +: DATA_W];
                    mem_wstrb <= in_strb;
                    mem_valid <= (in_strb != '0);
                end
                SEND: begin
                    if (hs && pf_valid) begin
                        mem_addr  <= {pf_entry[ADDR_LSB +: ADDR_W], {BYTE_W{1'b0}}};
                        mem_wdata <= pf_entry[DATA_LSB +: DATA_W];
                        mem_wstrb <= pf_entry[STRB_LSB +: STRB_W];
                        mem_valid <= 1'b1;
                    end else if (hs) begin
                        mem_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_write_buffer_drain.sv
// Directed self-checking bench for write_buffer_drain with a FIFO model.
// Prefetch steps are compiled in when WBUF_DRAIN_PREFETCH_EN is defined.
module tb_write_buffer_drain;

    logic        clock;
    logic        reset;
    logic        buf_empty;
    logic [65:0] buf_dataout;
    logic        buf_rd;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic        drain_idle;

    logic [65:0] fifo_mem [0:15];
    int          wr_ptr;
    int          rd_ptr;
    int          hs_cnt;
    int          rd_cnt;
    int          bad_rd;
    logic [31:0] hs_log [0:15];

    int n_cmp;
    int n_err;
    int hs0;
    int rd0;

    write_buffer_drain dut (
        .clock       (clock),
        .reset       (reset),
        .buf_empty   (buf_empty),
        .buf_dataout (buf_dataout),
        .buf_rd      (buf_rd),
        .mem_valid   (mem_valid),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_ready   (mem_ready),
        .drain_idle  (drain_idle)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign buf_empty = (wr_ptr == rd_ptr);

    initial begin
        rd_ptr      = 0;
        buf_dataout = '0;
        hs_cnt      = 0;
        rd_cnt      = 0;
        bad_rd      = 0;
    end

    // FIFO with registered read data, plus bus monitor
    always @(posedge clock) begin
        if (buf_rd && !buf_empty) begin
            buf_dataout <= fifo_mem[rd_ptr];
            rd_ptr      <= rd_ptr + 1;
        end
        if (buf_rd)              rd_cnt <= rd_cnt + 1;
        if (buf_rd && buf_empty) bad_rd <= bad_rd + 1;
        if (mem_valid && mem_ready) begin
            hs_log[hs_cnt] <= mem_addr;
            hs_cnt         <= hs_cnt + 1;
        end
    end

    function automatic logic [65:0] ent(input logic [29:0] a,
                                        input logic [31:0] d,
                                        input logic [3:0]  s);
        return {a, d, s};
    endfunction

    task automatic push(input logic [65:0] e);
        fifo_mem[wr_ptr] = e;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        wr_ptr    = 0;
        reset     = 1'b1;
        mem_ready = 1'b0;
        repeat (3) tick();

        chk("rst_valid", 64'(mem_valid), 64'd0);
        chk("rst_addr",  64'(mem_addr),  64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_wstrb", 64'(mem_wstrb), 64'd0);
        chk("rst_rd",    64'(buf_rd),    64'd0);
        chk("rst_idle",  64'(drain_idle), 64'd1);
        reset = 1'b0;
        tick();

        // single write
        mem_ready = 1'b1;
        hs0 = hs_cnt;
        rd0 = rd_cnt;
        push(ent(30'h10, 32'hDEADBEEF, 4'hF));
        #1;
        chk("sw_rd0",   64'(buf_rd),     64'd1);
        chk("sw_idle0", 64'(drain_idle), 64'd0);
        tick();
        chk("sw_rd1",    64'(buf_rd),    64'd0);
        chk("sw_valid1", 64'(mem_valid), 64'd0);
        tick();
        chk("sw_valid2", 64'(mem_valid), 64'd1);
        chk("sw_addr",   64'(mem_addr),  64'h40);
        chk("sw_wdata",  64'(mem_wdata), 64'hDEADBEEF);
        chk("sw_wstrb",  64'(mem_wstrb), 64'hF);
        tick();
        chk("sw_valid3", 64'(mem_valid),  64'd0);
        chk("sw_idle3",  64'(drain_idle), 64'd1);
        chk("sw_hs",     64'(hs_cnt - hs0), 64'd1);
        chk("sw_rdcnt",  64'(rd_cnt - rd0), 64'd1);

        // backpressure with a second entry waiting behind
        tick();
        mem_ready = 1'b0;
        hs0 = hs_cnt;
        rd0 = rd_cnt;
        push(ent(30'h123, 32'hCAFEF00D, 4'h5));
        push(ent(30'h3FFF_FFFF, 32'h0, 4'h8));
        #1;
        chk("bp_rd0", 64'(buf_rd), 64'd1);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(mem_valid), 64'd1);
            chk("bp_addr",  64'(mem_addr),  64'h48C);
            chk("bp_wdata", 64'(mem_wdata), 64'hCAFEF00D);
            chk("bp_wstrb", 64'(mem_wstrb), 64'h5);
            chk("bp_nord",  64'(buf_rd),    64'd0);
            if (i < 4) tick();
        end
        mem_ready = 1'b1;
        tick();
        chk("bp_hs",     64'(hs_cnt - hs0), 64'd1);
        chk("bp_rdcnt",  64'(rd_cnt - rd0), 64'd1);
        chk("bp_rdnext", 64'(buf_rd),    64'd1);
        chk("bp_vdrop",  64'(mem_valid), 64'd0);
        tick();
        tick();
        chk("max_valid", 64'(mem_valid), 64'd1);
        chk("max_addr",  64'(mem_addr),  64'hFFFF_FFFC);
        chk("max_wstrb", 64'(mem_wstrb), 64'h8);
        tick();
        chk("max_idle",  64'(drain_idle), 64'd1);
        chk("max_hs",    64'(hs_cnt - hs0), 64'd2);

        // zero strobe entry dropped, next one issued
        tick();
        hs0 = hs_cnt;
        rd0 = rd_cnt;
        push(ent(30'h5, 32'h1111, 4'h0));
        push(ent(30'h6, 32'h2222, 4'h3));
        #1;
        chk("zs_rd0", 64'(buf_rd), 64'd1);
        tick();
        chk("zs_v1", 64'(mem_valid), 64'd0);
        tick();
        chk("zs_v2",  64'(mem_valid), 64'd0);
        chk("zs_rd2", 64'(buf_rd),    64'd1);
        tick();
        chk("zs_v3", 64'(mem_valid), 64'd0);
        tick();
        chk("zs_v4",    64'(mem_valid), 64'd1);
        chk("zs_addr",  64'(mem_addr),  64'h18);
        chk("zs_wdata", 64'(mem_wdata), 64'h2222);
        chk("zs_wstrb", 64'(mem_wstrb), 64'h3);
        tick();
        chk("zs_idle",  64'(drain_idle), 64'd1);
        chk("zs_rdcnt", 64'(rd_cnt - rd0), 64'd2);
        chk("zs_hs",    64'(hs_cnt - hs0), 64'd1);

        // reset while a write is stalled
        tick();
        mem_ready = 1'b0;
        hs0 = hs_cnt;
        push(ent(30'h7, 32'h7777, 4'hF));
        tick();
        tick();
        chk("rs_valid0", 64'(mem_valid), 64'd1);
        reset = 1'b1;
        tick();
        chk("rs_valid1", 64'(mem_valid), 64'd0);
        chk("rs_addr",   64'(mem_addr),  64'd0);
        chk("rs_rd",     64'(buf_rd),    64'd0);
        chk("rs_idle",   64'(drain_idle), 64'd1);
        reset = 1'b0;
        mem_ready = 1'b1;
        tick();
        tick();
        chk("rs_valid2", 64'(mem_valid), 64'd0);
        chk("rs_rd2",    64'(buf_rd),    64'd0);
        chk("rs_hs",     64'(hs_cnt - hs0), 64'd0);

`ifdef WBUF_DRAIN_PREFETCH_EN
        // four queued entries; the second comes from the skid
        tick();
        mem_ready = 1'b0;
        hs0 = hs_cnt;
        rd0 = rd_cnt;
        push(ent(30'h100, 32'hA0, 4'hF));
        push(ent(30'h101, 32'hA1, 4'hF));
        push(ent(30'h102, 32'hA2, 4'hF));
        push(ent(30'h103, 32'hA3, 4'hF));
        tick();
        tick();
        chk("pf_v0",   64'(mem_valid), 64'd1);
        chk("pf_rdpf", 64'(buf_rd),    64'd1);
        tick();
        tick();
        mem_ready = 1'b1;
        tick();
        chk("pf_b2b_v",  64'(mem_valid), 64'd1);
        chk("pf_b2b_a",  64'(mem_addr),  64'h404);
        chk("pf_b2b_hs", 64'(hs_cnt - hs0), 64'd1);
        tick();
        chk("pf_hs2", 64'(hs_cnt - hs0), 64'd2);
        tick();
        tick();
        tick();
        tick();
        chk("pf_busy", 64'(drain_idle), 64'd0);
        chk("pf_v3",   64'(mem_valid),  64'd1);
        tick();
        chk("pf_idle", 64'(drain_idle), 64'd1);
        chk("pf_hs",   64'(hs_cnt - hs0), 64'd4);
        chk("pf_rdc",  64'(rd_cnt - rd0), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("pf_order", 64'(hs_log[hs0 + i]), 64'(32'h400 + 32'(4 * i)));
        end
`endif

        chk("no_rd_empty", 64'(bad_rd), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
